// File: rtl/strip_pkg.sv
// Shared types and constants for the parallel serial LED strip driver.
package strip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

    // Colour-order word sizes: GRB pixels and GRBW pixels.
    localparam int GRB24  = 24;
    localparam int GRBW32 = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strip_driver_multi_counter.sv
// Free-running up counter with synchronous clear and count enable.
module counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (en) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/strip_driver_multi.sv
// Parallel WS2812-class driver: shifts NUM_STRIPS pixel streams from a shared
// line buffer, prefetching the next pixel so bit timing stays gapless.
module strip_driver_multi
    import strip_pkg::*;
#(
    parameter int NUM_STRIPS     = 4,
    parameter int LEDS_PER_STRIP = 128,
    parameter int BITS_PER_LED   = GRB24,
    parameter int T0H            = 10,
    parameter int T1H            = 30,
    parameter int TBIT           = 55,
    parameter int TRESET         = 2750,
    localparam int AW            = max_int(1, $clog2(LEDS_PER_STRIP))
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               auto_refresh,
    output logic                               busy,
    output logic                               frame_done,
    output logic [AW-1:0]                      strip_raddr,
    output logic                               strip_re,
    input  logic [NUM_STRIPS*BITS_PER_LED-1:0] strip_rdata,
    output logic [NUM_STRIPS-1:0]              strip
);

    localparam int B  = BITS_PER_LED;
    localparam int PW = max_int(1, $clog2(max_int(TBIT, TRESET)));
    localparam int BW = max_int(1, $clog2(B));

    localparam logic [PW-1:0] PH_BIT_LAST = PW'(TBIT - 1);
    localparam logic [PW-1:0] PH_RST_LAST = PW'(TRESET - 1);
    localparam logic [PW-1:0] PH_T0H      = PW'(T0H);
    localparam logic [PW-1:0] PH_T1H      = PW'(T1H);
    localparam logic [PW-1:0] PH_ONE      = PW'(1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(B - 1);
    localparam logic [AW-1:0] LED_LAST    = AW'(LEDS_PER_STRIP - 1);

    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("strip_driver_multi: timing requires 1 <= T0H < T1H < TBIT");
    end

    state_t state, state_n;

    logic [PW-1:0] ph, ph_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [AW-1:0] led_cnt, led_n;
    logic ph_clr, ph_en, bit_clr, bit_en, led_clr, led_en;
    logic ph_last, bit_last, led_last, latch_end;
    logic do_load, do_shift, do_next, stage_cap, prefetch_n, send_n;
    logic [NUM_STRIPS-1:0] level_n;

    counter #(.W(PW)) u_ph  (.clk(sys_clk), .rst(rst || ph_clr),  .en(ph_en),  .out(ph));
    counter #(.W(BW)) u_bit (.clk(sys_clk), .rst(rst || bit_clr), .en(bit_en), .out(bit_cnt));
    counter #(.W(AW)) u_led (.clk(sys_clk), .rst(rst || led_clr), .en(led_en), .out(led_cnt));

    always_comb begin
        ph_last   = (ph == PH_BIT_LAST);
        bit_last  = (bit_cnt == BIT_LAST);
        led_last  = (led_cnt == LED_LAST);
        latch_end = (ph == PH_RST_LAST);
        state_n   = state;
        ph_clr    = 1'b1;
        ph_en     = 1'b0;
        bit_clr   = 1'b1;
        bit_en    = 1'b0;
        led_clr   = 1'b1;
        led_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start || auto_refresh) state_n = FETCH;
            end
            FETCH: state_n = LOAD;
            LOAD:  state_n = SEND;
            SEND: begin
                ph_clr  = ph_last;
                ph_en   = !ph_last;
                bit_clr = ph_last && bit_last;
                bit_en  = ph_last && !bit_last;
                led_clr = ph_last && bit_last && led_last;
                led_en  = ph_last && bit_last && !led_last;
                if (ph_last && bit_last && led_last) state_n = LATCH;
            end
            LATCH: begin
                ph_clr = latch_end;
                ph_en  = !latch_end;
                if (latch_end) state_n = (auto_refresh || start) ? FETCH : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from next-cycle counter
    // values; this keeps the strip level aligned with the live phase count.
    always_comb begin
        ph_n  = ph_clr  ? '0 : (ph_en  ? ph + 1'b1      : ph);
        bit_n = bit_clr ? '0 : (bit_en ? bit_cnt + 1'b1 : bit_cnt);
        led_n = led_clr ? '0 : (led_en ? led_cnt + 1'b1 : led_cnt);
        send_n     = (state_n == SEND);
        prefetch_n = send_n && (bit_n == BIT_LAST) && (ph_n == '0) && (led_n != LED_LAST);
        do_load    = (state == LOAD);
        do_shift   = (state == SEND) && ph_last && !bit_last;
        do_next    = (state == SEND) && ph_last && bit_last && !led_last;
        stage_cap  = (state == SEND) && bit_last && (ph == PH_ONE) && !led_last;
    end

    for (genvar i = 0; i < NUM_STRIPS; i++) begin : g_strip
        logic [B-1:0] shift_q, shift_d, stage_q;

        always_comb begin
            shift_d = shift_q;
            if (do_load) begin
                shift_d = strip_rdata[i*B +: B];
            end else if (do_shift) begin
                shift_d = shift_q << 1;
            end else if (do_next) begin
                shift_d = stage_q;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                shift_q <= '0;
                stage_q <= '0;
            end else begin
                shift_q <= shift_d;
                if (stage_cap) stage_q <= strip_rdata[i*B +: B];
            end
        end

        assign level_n[i] = send_n && ((ph_n < PH_T0H) || ((ph_n < PH_T1H) && shift_d[B-1]));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            strip_re    <= 1'b0;
            strip_raddr <= '0;
            strip       <= '0;
        end else begin
            state       <= state_n;
            busy        <= (state_n != IDLE);
            frame_done  <= (state == LATCH) && latch_end;
            strip_re    <= (state_n == FETCH) || prefetch_n;
            strip_raddr <= prefetch_n ? led_n + 1'b1 : led_n;
            strip       <= level_n;
        end
    end

endmodule

// File: tb/tb_strip_driver_multi.sv
// Directed bench: three driver configurations share one clock and are
// exercised in turn against a cycle-timing model of the serial waveform.
module tb_strip_driver_multi;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // dut_a: 2 strips, 2 LEDs, 24 bits
    logic start_a = 1'b0, auto_a = 1'b0, busy_a, fd_a, re_a;
    logic [0:0]  raddr_a;
    logic [47:0] rdata_a = '0;
    logic [1:0]  strip_a;
    logic [47:0] mem_a [2];

    // dut_b: 4 strips, 3 LEDs, 24 bits
    logic start_b = 1'b0, auto_b = 1'b0, busy_b, fd_b, re_b;
    logic [1:0]  raddr_b;
    logic [95:0] rdata_b = '0;
    logic [3:0]  strip_b;
    logic [95:0] mem_b [3];

    // dut_c: 1 strip, 1 LED, 32 bits
    logic start_c = 1'b0, auto_c = 1'b0, busy_c, fd_c, re_c;
    logic [0:0]  raddr_c;
    logic [31:0] rdata_c = '0;
    logic [0:0]  strip_c;
    logic [31:0] mem_c0;

    strip_driver_multi #(.NUM_STRIPS(2), .LEDS_PER_STRIP(2)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .start(start_a), .auto_refresh(auto_a),
        .busy(busy_a), .frame_done(fd_a), .strip_raddr(raddr_a), .strip_re(re_a),
        .strip_rdata(rdata_a), .strip(strip_a));

    strip_driver_multi #(.NUM_STRIPS(4), .LEDS_PER_STRIP(3)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .start(start_b), .auto_refresh(auto_b),
        .busy(busy_b), .frame_done(fd_b), .strip_raddr(raddr_b), .strip_re(re_b),
        .strip_rdata(rdata_b), .strip(strip_b));

    strip_driver_multi #(.NUM_STRIPS(1), .LEDS_PER_STRIP(1), .BITS_PER_LED(32)) dut_c (
        .sys_clk(sys_clk), .rst(rst), .start(start_c), .auto_refresh(auto_c),
        .busy(busy_c), .frame_done(fd_c), .strip_raddr(raddr_c), .strip_re(re_c),
        .strip_rdata(rdata_c), .strip(strip_c));

    always @(posedge sys_clk) begin
        if (re_a) rdata_a <= mem_a[raddr_a];
        if (re_b && raddr_b < 2'd3) rdata_b <= mem_b[raddr_b];
        if (re_c) rdata_c <= mem_c0;
    end

    // Global bit index being sent in cycle c (first high at cycle 3), or -1.
    function automatic int bit_idx(input int c, input int nleds, input int nbits);
        if (c < 3) return -1;
        if ((c - 3) / 55 >= nleds * nbits) return -1;
        return (c - 3) / 55;
    endfunction

    task automatic do_reset();
        @(posedge sys_clk); #1 rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge sys_clk); #1 rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (strip_a !== 2'b00) begin errors++; $display("FAIL reset_strip_a: got %b expected 00", strip_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_fd_a: got %b expected 0", fd_a); end
        checks++; if (re_a !== 1'b0) begin errors++; $display("FAIL reset_re_a: got %b expected 0", re_a); end
        checks++; if (raddr_a !== 1'b0) begin errors++; $display("FAIL reset_raddr_a: got %b expected 0", raddr_a); end
        @(posedge sys_clk); #1 rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++; if (busy_b !== 1'b0 || strip_b !== 4'h0 || re_b !== 1'b0) begin
            errors++; $display("FAIL idle_b: got busy=%b strip=%h re=%b expected 0 0 0", busy_b, strip_b, re_b);
        end
        checks++; if (busy_c !== 1'b0 || strip_c !== 1'b0 || fd_c !== 1'b0) begin
            errors++; $display("FAIL idle_c: got busy=%b strip=%b fd=%b expected 0 0 0", busy_c, strip_c, fd_c);
        end
    endtask

    task automatic test_pattern();
        int bad_s [2] = '{0, 0};
        int bad_ctl = 0;
        int first_ctl = -1;
        int bi, ph;
        logic ex;
        @(posedge sys_clk); #1 start_a = 1'b1;
        for (int c = 1; c <= 5400; c++) begin
            @(posedge sys_clk); #1;
            if (c == 1) start_a = 1'b0;
            @(negedge sys_clk);
            for (int s = 0; s < 2; s++) begin
                bi = bit_idx(c, 2, 24);
                ph = (c - 3) % 55;
                ex = (bi >= 0) && ((ph < 10) || ((ph < 30) && mem_a[bi / 24][s*24 + 23 - bi % 24]));
                if (strip_a[s] !== ex) bad_s[s]++;
            end
            if (re_a !== ((c == 1) || (c == 1268)) || busy_a !== (c <= 5392) || fd_a !== (c == 5393)) begin
                bad_ctl++;
                if (first_ctl < 0) first_ctl = c;
            end
            if (c == 1) begin
                checks++; if (re_a !== 1'b1 || raddr_a !== 1'b0) begin errors++; $display("FAIL fetch_strobe: got re=%b addr=%0d expected 1 0", re_a, raddr_a); end
            end
            if (c == 3) begin
                checks++; if (strip_a !== 2'b11) begin errors++; $display("FAIL first_high: got %b expected 11", strip_a); end
            end
            if (c == 32 || c == 33) begin
                checks++; if (strip_a[0] !== (c == 32)) begin errors++; $display("FAIL long_high_edge c=%0d: got %b expected %b", c, strip_a[0], c == 32); end
            end
            if (c == 12 || c == 13) begin
                checks++; if (strip_a[1] !== (c == 12)) begin errors++; $display("FAIL short_high_edge c=%0d: got %b expected %b", c, strip_a[1], c == 12); end
            end
            if (c == 417 || c == 453) begin
                checks++; if (strip_a[0] !== (c == 417)) begin errors++; $display("FAIL ones_to_zeros c=%0d: got %b expected %b", c, strip_a[0], c == 417); end
            end
            if (c == 1297) begin
                checks++; if (strip_a[1] !== 1'b1) begin errors++; $display("FAIL last_bit_long: got %b expected 1", strip_a[1]); end
            end
            if (c == 1268) begin
                checks++; if (re_a !== 1'b1 || raddr_a !== 1'b1) begin errors++; $display("FAIL prefetch_a: got re=%b addr=%0d expected 1 1", re_a, raddr_a); end
            end
            if (c == 5393) begin
                checks++; if (fd_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL frame_end_a: got fd=%b busy=%b expected 1 0", fd_a, busy_a); end
            end
        end
        for (int s = 0; s < 2; s++) begin
            checks++; if (bad_s[s] !== 0) begin errors++; $display("FAIL wave_a_strip%0d: %0d wrong cycles, expected 0", s, bad_s[s]); end
        end
        checks++; if (bad_ctl !== 0) begin errors++; $display("FAIL ctl_a: %0d wrong cycles (first %0d), expected 0", bad_ctl, first_ctl); end
    endtask

    task automatic test_start_held();
        int busy_low = 0;
        do_reset();
        @(posedge sys_clk); #1 start_a = 1'b1;
        for (int c = 1; c <= 5400; c++) begin
            @(posedge sys_clk); #1;
            @(negedge sys_clk);
            if (busy_a !== 1'b1) busy_low++;
            if (c == 5393) begin
                checks++; if (fd_a !== 1'b1 || re_a !== 1'b1 || raddr_a !== 1'b0) begin
                    errors++; $display("FAIL restart_fetch: got fd=%b re=%b addr=%0d expected 1 1 0", fd_a, re_a, raddr_a);
                end
            end
            if (c == 5395) begin
                checks++; if (strip_a !== 2'b11) begin errors++; $display("FAIL restart_high: got %b expected 11", strip_a); end
            end
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL held_busy: low %0d cycles, expected 0", busy_low); end
        start_a = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        @(posedge sys_clk); #1 start_a = 1'b1;
        for (int c = 1; c <= 1700; c++) begin
            @(posedge sys_clk); #1;
            if (c == 1) start_a = 1'b0;
            if (c == 1343) rst = 1'b1;
            if (c == 1344) rst = 1'b0;
            @(negedge sys_clk);
            if (c == 1343) begin
                checks++; if (strip_a !== 2'b11 || busy_a !== 1'b1) begin errors++; $display("FAIL pre_reset: got strip=%b busy=%b expected 11 1", strip_a, busy_a); end
            end
            if (c == 1344) begin
                checks++; if (strip_a !== 2'b00 || busy_a !== 1'b0) begin errors++; $display("FAIL post_reset: got strip=%b busy=%b expected 00 0", strip_a, busy_a); end
            end
            if (c >= 1344 && (re_a !== 1'b0 || strip_a !== 2'b00 || busy_a !== 1'b0)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL truncated_quiet: %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_gapless();
        int bad_w = 0, bad_gap = 0, rises = 0, last_rise = -1, bad_re = 0;
        int bi, ph;
        logic prev = 1'b0;
        logic ex;
        do_reset();
        @(posedge sys_clk); #1 start_b = 1'b1;
        for (int c = 1; c <= 6720; c++) begin
            @(posedge sys_clk); #1;
            if (c == 1) start_b = 1'b0;
            @(negedge sys_clk);
            for (int s = 0; s < 4; s++) begin
                bi = bit_idx(c, 3, 24);
                ph = (c - 3) % 55;
                ex = (bi >= 0) && ((ph < 10) || ((ph < 30) && mem_b[bi / 24][s*24 + 23 - bi % 24]));
                if (strip_b[s] !== ex) bad_w++;
            end
            if (strip_b[0] === 1'b1 && prev === 1'b0) begin
                rises++;
                if (last_rise >= 0 && c - last_rise != 55) bad_gap++;
                last_rise = c;
            end
            prev = strip_b[0];
            if (re_b !== ((c == 1) || (c == 1268) || (c == 2588))) bad_re++;
            if (c == 1268 || c == 2588) begin
                checks++; if (re_b !== 1'b1 || raddr_b !== ((c == 1268) ? 2'd1 : 2'd2)) begin
                    errors++; $display("FAIL prefetch_b c=%0d: got re=%b addr=%0d expected 1 %0d", c, re_b, raddr_b, (c == 1268) ? 1 : 2);
                end
            end
            if (c == 6712 || c == 6713) begin
                checks++; if (busy_b !== (c == 6712) || fd_b !== (c == 6713)) begin
                    errors++; $display("FAIL frame_len_b c=%0d: got busy=%b fd=%b expected %b %b", c, busy_b, fd_b, c == 6712, c == 6713);
                end
            end
        end
        checks++; if (bad_w !== 0) begin errors++; $display("FAIL wave_b: %0d wrong samples, expected 0", bad_w); end
        checks++; if (rises !== 72 || bad_gap !== 0) begin errors++; $display("FAIL gapless: got %0d rises %0d bad gaps, expected 72 0", rises, bad_gap); end
        checks++; if (bad_re !== 0) begin errors++; $display("FAIL re_pattern_b: %0d wrong cycles, expected 0", bad_re); end
    endtask

    task automatic test_auto_refresh();
        int fds = 0, busy_low = 0, bad_fd = 0;
        do_reset();
        @(posedge sys_clk); #1 auto_b = 1'b1;
        for (int c = 1; c <= 13430; c++) begin
            @(posedge sys_clk); #1;
            @(negedge sys_clk);
            if (busy_b !== 1'b1) busy_low++;
            if (fd_b === 1'b1) fds++;
            if (fd_b !== ((c == 6713) || (c == 13425))) bad_fd++;
            if (c == 6713) begin
                checks++; if (re_b !== 1'b1 || raddr_b !== 2'd0) begin errors++; $display("FAIL auto_fetch: got re=%b addr=%0d expected 1 0", re_b, raddr_b); end
            end
        end
        checks++; if (fds !== 2 || bad_fd !== 0) begin errors++; $display("FAIL auto_period: got %0d pulses %0d misplaced, expected 2 0", fds, bad_fd); end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL auto_busy: low %0d cycles, expected 0", busy_low); end
        auto_b = 1'b0;
        do_reset();
    endtask

    task automatic test_grbw();
        int runs [$];
        int run = 0, res = 0, bad_mid = 0;
        logic fd_seen = 1'b0;
        @(posedge sys_clk); #1 start_c = 1'b1;
        for (int c = 1; c <= 4520; c++) begin
            @(posedge sys_clk); #1;
            if (c == 1) start_c = 1'b0;
            @(negedge sys_clk);
            if (strip_c[0] === 1'b1) run++;
            else if (run > 0) begin runs.push_back(run); run = 0; end
            if (re_c === 1'b1) res++;
            if (c == 4513) fd_seen = fd_c;
        end
        checks++; if (runs.size() !== 32) begin errors++; $display("FAIL grbw_bits: got %0d highs expected 32", runs.size()); end
        if (runs.size() == 32) begin
            checks++; if (runs[0] !== 30 || runs[31] !== 30) begin errors++; $display("FAIL grbw_ends: got %0d %0d expected 30 30", runs[0], runs[31]); end
            for (int i = 1; i < 31; i++) if (runs[i] != 10) bad_mid++;
            checks++; if (bad_mid !== 0) begin errors++; $display("FAIL grbw_mid: %0d wrong highs, expected 0", bad_mid); end
        end
        checks++; if (res !== 1) begin errors++; $display("FAIL grbw_strobes: got %0d expected 1", res); end
        checks++; if (fd_seen !== 1'b1) begin errors++; $display("FAIL grbw_frame_done: got %b expected 1", fd_seen); end
    endtask

    initial begin
        mem_a[0] = {24'h000001, 24'hFF0000};
        mem_a[1] = {24'hAAAAAA, 24'h800001};
        mem_b[0] = {24'h123456, 24'hABCDEF, 24'h00FF00, 24'hC3A55A};
        mem_b[1] = {24'hFFFFFF, 24'h000000, 24'h5A5A5A, 24'h0F0F0F};
        mem_b[2] = {24'h800001, 24'h7FFFFE, 24'hDEAD01, 24'h96C3E1};
        mem_c0   = 32'h8000_0001;
        test_reset();
        test_pattern();
        test_start_held();
        test_reset_mid_frame();
        test_gapless();
        test_auto_refresh();
        test_grbw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strip_driver_multi.md
# strip_driver_multi

Parametrised serial LED driver that shifts NUM_STRIPS single-wire (WS2812-class) pixel streams out in parallel from a shared pixel line buffer. Each buffer word holds one pixel per strip, already gamma-corrected and in wire colour order. Each frame is started by a level-sensitive start request or by auto-refresh. The next pixel is prefetched during the current pixel's last bit, so bit timing is gapless across pixel boundaries. It replaces the fixed four-strip, 128-LED, 24-bit driver in the strip output path.

## Interface
- NUM_STRIPS, 4: number of parallel strip outputs (≥1)
- LEDS_PER_STRIP, 128: pixels per strip per frame (≥1)
- BITS_PER_LED, 24: bits shifted per pixel (24 = GRB, 32 = GRBW)
- T0H, 10: high cycles for a 0 bit
- T1H, 30: high cycles for a 1 bit
- TBIT, 55: total cycles per bit; legal only if 1 ≤ T0H < T1H < TBIT; elaboration error otherwise
- TRESET, 2750: low cycles of the end-of-frame latch gap
- AW: localparam, max(1, $clog2(LEDS_PER_STRIP))
- sys_clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- start  in  1  frame request; level, sampled only in IDLE
- auto_refresh  in  1  when high, a new frame starts right after LATCH with no start needed
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on the LATCH→IDLE/FETCH transition
- strip_raddr  out  AW  pixel index into the line buffer
- strip_re  out  1  line-buffer read strobe; data is valid the following cycle
- strip_rdata  in  NUM_STRIPS*BITS_PER_LED  strip i uses slice [(i+1)*B-1 : i*B], MSB sent first
- strip  out  NUM_STRIPS  registered serial outputs

## Operation
- States: IDLE, FETCH, LOAD, SEND, LATCH.
- IDLE: led_cnt=0, bit_cnt=0, ph=0. Goes to FETCH if start or auto_refresh.
- FETCH (1 cycle): strip_re=1, strip_raddr=0.
- LOAD (1 cycle): capture strip_rdata into the per-strip shift registers.
- SEND: phase counter ph runs 0..TBIT-1.
  - Combinational level per strip: (ph < T0H) or (ph < T1H and shift MSB = 1).
  - At ph = TBIT-1, if bit_cnt < B-1: shift left, bit_cnt++.
  - At ph = TBIT-1, if bit_cnt = B-1 and this is not the last LED: load the shift registers from staging, bit_cnt=0, led_cnt++.
  - At ph = TBIT-1, if bit_cnt = B-1 and this is the last LED: go to LATCH.
- Prefetch: in SEND with bit_cnt = B-1, ph = 0, and led_cnt < LEDS_PER_STRIP-1, assert strip_re with strip_raddr = led_cnt+1. The staging register captures strip_rdata at ph = 1.
- strip_raddr equals led_cnt at all other times; it is meaningful only while strip_re is high.
- LATCH: all strip levels low for TRESET cycles. Then go to FETCH if auto_refresh (or start) is high, else IDLE.
- start is ignored outside IDLE and LATCH exit; there is no queued request.

## Timing
- Reset values: strip=0, busy=0, frame_done=0, strip_re=0, strip_raddr=0, state=IDLE, all counters 0.
- A reset asserted mid-frame truncates the frame. Outputs are low from the next edge, and the buffer is not read again until a new start.
- strip outputs are registered: the level computed in cycle n appears at cycle n+1.
- Start latency: start is sampled high in IDLE at cycle 0. strip_re is high in cycle 1 (FETCH), and the first strip high edge appears at cycle 3.
- Every bit is exactly TBIT cycles, including across pixel boundaries.
- Frame length from the first strip high to the end of LATCH: LEDS_PER_STRIP*B*TBIT + TRESET cycles.
- Counter widths: ph is $clog2(max(TBIT,TRESET)) bits and is reused in LATCH; bit_cnt is $clog2(B) bits; led_cnt is AW bits. No wrap occurs because terminal compares end each count.
- LEDS_PER_STRIP = 1: no prefetch is issued, and the frame goes straight to LATCH after bit B-1.

## Structure
- Shared package strip_pkg: state enum, and the colour-order constants GRB24 and GRBW32.
- Counters reuse the existing `counter` module (clk/rst/en/out), one instance each for ph, bit_cnt and led_cnt.
- The per-strip shift and staging registers are a generate loop over NUM_STRIPS; no extra sub-module.

## Test plan
- Defaults apply unless a scenario says otherwise; vectors are listed strip 0 → strip NUM_STRIPS-1.
- NUM_STRIPS=2, LEDS=2, pixel0={24'hFF0000, 24'h000001}: start pulse → strip0 high 30 cycles then low 25, eight times, then high 10 cycles ×16; strip1 high 10 cycles ×23, then high 30 on bit 23.
- Gapless check, LEDS=3: every rising edge of strip0 is exactly 55 cycles after the previous one across pixel boundaries. strip_re pulses at cycles 1, 1+2+23*55, and 1+2+47*55.
- auto_refresh held high: frame_done pulses every 3*24*55+2750+2 cycles, and busy never drops.
- start held high in SEND, auto_refresh=0: after LATCH, busy falls for ≥1 cycle only if start is low; otherwise the next frame starts immediately.
- rst asserted at SEND ph=20 of pixel 1 → next cycle strip=0, busy=0, and no strip_re until the next start.
- BITS_PER_LED=32, LEDS=1, data 32'h8000_0001: first and last bits are long (30-cycle) highs, the other 30 are short; no prefetch strobe.
